// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready word input and a framed bit stream output.
// A new word can be taken on the last-bit cycle, so back-to-back words leave no gap on dout.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             lastBit;
  logic             accept;

  // Ready is gated by reset_n so nothing upstream sees a handshake during reset.
  always_comb begin
    lastBit   = (state_q == SHIFT) && (count_q == LAST);
    din_ready = reset_n && ((state_q == IDLE) || lastBit);
    accept    = din_valid && din_ready;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = din;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (count_q == LAST) begin
          if (accept) begin
            shreg_d = din;
            count_d = '0;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            count_d = '0;
          end
        end else begin
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  // Outputs decode registered state only, so they go quiet on the reset edge.
  always_comb begin
    dout        = 1'b0;
    dout_valid  = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    if (state_q == SHIFT) begin
      dout        = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      dout_valid  = 1'b1;
      frame_start = (count_q == '0);
      done        = (count_q == LAST);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: one MSB-first and one LSB-first serializer; every accepted word
// queues its expected bit stream, and each falling edge compares the DUT output against it.
module tb_piso_serializer;

  localparam int W = 8;

  typedef struct packed {
    logic d;
    logic fs;
    logic dn;
  } expBit_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] din        [2];
  logic         dinValid   [2];
  logic         dinReady   [2];
  logic         dout       [2];
  logic         doutValid  [2];
  logic         frameStart [2];
  logic         done       [2];

  expBit_t msbQ[$];
  expBit_t lsbQ[$];
  int      checkCount = 0;
  int      errorCount = 0;

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clock(clock), .reset_n(reset_n), .din(din[0]), .din_valid(dinValid[0]),
    .din_ready(dinReady[0]), .dout(dout[0]), .dout_valid(doutValid[0]),
    .frame_start(frameStart[0]), .done(done[0])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clock(clock), .reset_n(reset_n), .din(din[1]), .din_valid(dinValid[1]),
    .din_ready(dinReady[1]), .dout(dout[1]), .dout_valid(doutValid[1]),
    .frame_start(frameStart[1]), .done(done[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic pushWord(input int lane, input logic [W-1:0] word);
    expBit_t e;
    for (int k = 0; k < W; k++) begin
      e.d  = (lane == 0) ? word[W-1-k] : word[k];
      e.fs = (k == 0);
      e.dn = (k == W - 1);
      if (lane == 0) msbQ.push_back(e);
      else lsbQ.push_back(e);
    end
  endtask

  function automatic int queueSize(input int lane);
    return (lane == 0) ? msbQ.size() : lsbQ.size();
  endfunction

  // Any pending expected bit means dout must be valid now; an empty queue means fully idle.
  task automatic monitorLane(input int lane, input logic vld, input logic d, input logic fs, input logic dn);
    expBit_t e;
    string   tag;
    if (queueSize(lane) == 0) begin
      tag = (lane == 0) ? "msb idle {valid,dout,start,done}" : "lsb idle {valid,dout,start,done}";
      checkOutput(tag, {28'd0, vld, d, fs, dn}, 32'd0);
    end else begin
      if (lane == 0) e = msbQ.pop_front();
      else e = lsbQ.pop_front();
      tag = (lane == 0) ? "msb bit {valid,dout,start,done}" : "lsb bit {valid,dout,start,done}";
      checkOutput(tag, {28'd0, vld, d, fs, dn}, {28'd0, 1'b1, e.d, e.fs, e.dn});
    end
  endtask

  always @(negedge clock) begin
    monitorLane(0, doutValid[0], dout[0], frameStart[0], done[0]);
    monitorLane(1, doutValid[1], dout[1], frameStart[1], done[1]);
  end

  task automatic applyStimulus(input int lane, input logic [W-1:0] word, input bit holdValid, output int waits);
    din[lane]      = word;
    dinValid[lane] = 1'b1;
    waits          = 0;
    #1;
    while (!dinReady[lane] && waits < 20) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (!dinReady[lane]) begin
      checkOutput("accept timeout", 32'd1, 32'd0);
      dinValid[lane] = 1'b0;
    end else begin
      @(posedge clock);
      pushWord(lane, word);
      @(negedge clock);
      if (!holdValid) dinValid[lane] = 1'b0;
    end
  endtask

  task automatic drainLane(input int lane);
    int n;
    n = 0;
    while (queueSize(lane) > 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drain leftover bits", queueSize(lane), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waits;
    bit  hold;
    reset_n     = 1'b0;
    din[0]      = 8'hFF;
    din[1]      = 8'hFF;
    dinValid[0] = 1'b1;
    dinValid[1] = 1'b1;

    repeat (2) begin
      @(negedge clock);
      #1;
      checkOutput("reset din_ready msb", dinReady[0], 32'd0);
      checkOutput("reset din_ready lsb", dinReady[1], 32'd0);
      checkOutput("reset dout_valid", doutValid[0], 32'd0);
      checkOutput("reset dout", dout[0], 32'd0);
    end
    reset_n     = 1'b1;
    dinValid[0] = 1'b0;
    dinValid[1] = 1'b0;
    #1;
    checkOutput("ready after reset msb", dinReady[0], 32'd1);
    checkOutput("ready after reset lsb", dinReady[1], 32'd1);
    repeat (4) @(negedge clock);

    $display("[TB] single word 0xE9, MSB first");
    applyStimulus(0, 8'hE9, 1'b0, waits);
    checkOutput("idle accept waits", waits, 32'd0);
    drainLane(0);

    $display("[TB] single word 0x01, LSB first");
    applyStimulus(1, 8'h01, 1'b0, waits);
    checkOutput("lsb idle accept waits", waits, 32'd0);
    drainLane(1);

    $display("[TB] back-to-back 0xA5, 0x3C with valid held");
    applyStimulus(0, 8'hA5, 1'b1, waits);
    applyStimulus(0, 8'h3C, 1'b0, waits);
    checkOutput("b2b cycles until ready", waits, 32'd7);
    drainLane(0);

    $display("[TB] word offered mid-frame at count 3");
    applyStimulus(0, 8'hA5, 1'b0, waits);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("ready at count 3", dinReady[0], 32'd0);
    applyStimulus(0, 8'h3C, 1'b0, waits);
    checkOutput("mid-frame cycles until ready", waits, 32'd4);
    drainLane(0);

    $display("[TB] reset at count 4 aborts the word");
    applyStimulus(0, 8'hC3, 1'b0, waits);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    msbQ.delete();
    lsbQ.delete();
    @(negedge clock);
    #1;
    checkOutput("abort dout_valid", doutValid[0], 32'd0);
    checkOutput("abort din_ready", dinReady[0], 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    applyStimulus(0, 8'h81, 1'b0, waits);
    checkOutput("post-abort accept waits", waits, 32'd0);
    drainLane(0);

    $display("[TB] random words, LSB first");
    for (int i = 0; i < 8; i++) begin
      hold = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(1, W'($urandom), hold, waits);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drainLane(1);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
